// File: rtl/prescaled_counter_pkg.sv
// prescaled_counter_pkg: shared sizing helper for the prescaler counter width.
package prescaled_counter_pkg;

    function automatic int pcnt_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/prescaled_counter_tick_gen.sv
// tick_gen: down-counting prescaler; step is high while enabled with pcnt at zero.
module tick_gen
    import prescaled_counter_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step
);
    localparam int PW = pcnt_width(TICK_DIV);
    localparam logic [PW-1:0] RELOAD = PW'(TICK_DIV - 1);
    logic [PW-1:0] pcnt;
    assign step = en && pcnt == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            pcnt <= RELOAD;
        else if (restart || step)
            pcnt <= RELOAD;
        else if (en)
            pcnt <= pcnt - 1'b1;
endmodule

// File: rtl/prescaled_counter.sv
// prescaled_counter: modulo counter stepped by tick_gen, with up/down, wrap/saturate,
// clear/load and cascade outputs (tick, wrap).
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    input  logic             up,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             at_limit
);
    // One extra bit keeps MODULUS = 2^WIDTH representable.
    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MODULUS - 1);
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return ({1'b0, v} > LIM) ? LIM[WIDTH-1:0] : v;
    endfunction
    logic             step, adv, hit;
    logic [WIDTH:0]   c1, stepped;
    logic [WIDTH-1:0] nxt;
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .restart(clr || load),
        .step   (step)
    );
    always_comb begin
        c1      = {1'b0, count};
        hit     = up ? c1 == LIM : c1 == '0;
        stepped = hit ? (sat_mode ? c1 : (up ? '0 : LIM)) : (up ? c1 + 1'b1 : c1 - 1'b1);
        adv     = step && !clr && !load;
        nxt     = clr ? '0 : load ? clamp(init) : adv ? stepped[WIDTH-1:0] : count;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count    <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            count    <= nxt;
            tick     <= adv;
            wrap     <= adv && hit && !sat_mode;
            at_limit <= up ? {1'b0, nxt} == LIM : nxt == '0;
        end
endmodule
